// File: rtl/pixel_stream_capture_pkg.sv
// Shared constants, FSM encodings and the pixel-pair FIFO entry layout.
// Optional CRC helper is built only with PIX_CAPTURE_CRC_EN.
package pixel_stream_capture_pkg;

  localparam int DEF_WIDTH      = 768;
  localparam int DEF_HEIGHT     = 512;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // 48 data bits + sof/eol/eof tags
  localparam int ENTRY_W = 51;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [23:0] px1;
    logic [23:0] px0;
  } pair_t;

`ifdef PIX_CAPTURE_CRC_EN
  // CRC-16-CCITT, MSB first, over R then G then B
  function automatic logic [15:0] crc16_px(
    input logic [15:0] crc,
    input logic [23:0] rgb
  );
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ rgb[i])
        c = {c[14:0], 1'b0} ^ 16'h1021;
      else
        c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/pixel_stream_capture_if.sv
// Bus bundle of the capture block: sync/pair input side and
// valid/ready pixel output side. slave = capture block, master = source/sink.
interface pixel_stream_capture_if;

  logic        VSYNC;
  logic        HSYNC;
  logic [7:0]  DATA_R0;
  logic [7:0]  DATA_G0;
  logic [7:0]  DATA_B0;
  logic [7:0]  DATA_R1;
  logic [7:0]  DATA_G1;
  logic [7:0]  DATA_B1;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  modport slave (
    input  VSYNC, HSYNC,
    input  DATA_R0, DATA_G0, DATA_B0,
    input  DATA_R1, DATA_G1, DATA_B1,
    input  out_ready,
    output out_valid, out_rgb,
    output out_sof, out_eol, out_eof
  );

  modport master (
    output VSYNC, HSYNC,
    output DATA_R0, DATA_G0, DATA_B0,
    output DATA_R1, DATA_G1, DATA_B1,
    output out_ready,
    input  out_valid, out_rgb,
    input  out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/pixel_stream_capture_fifo.sv
// pix_pair_fifo: synchronous FIFO for pixel-pair entries.
// Ports: clk, rst, push_i/din_i, pop_i/dout_o (head), full_o, empty_o.
module pix_pair_fifo
  import pixel_stream_capture_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk) begin
    if (push_i)
      mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i)
        wr_q <= wr_q + ONE;
      if (pop_i)
        rd_q <= rd_q + ONE;
    end
  end

  // extra pointer MSB separates full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/pixel_stream_capture.sv
// Capture of HSYNC-qualified dual-pixel RGB: geometry FSM, pair FIFO,
// 2:1 serializer onto valid/ready. Ports: HCLK, HRESETn (active-high
// async), bus (slave), frame_done, ovf_err, geom_err; frame_crc with
// PIX_CAPTURE_CRC_EN defined.
module pixel_stream_capture
  import pixel_stream_capture_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic HCLK,
  input  logic HRESETn,
  pixel_stream_capture_if.slave bus,
  output logic frame_done,
  output logic ovf_err,
  output logic geom_err
`ifdef PIX_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      col_q, col_d, col_w;
  logic [RW-1:0]      row_q, row_d, row_w;
  logic               act_w;
  logic               geom_q, geom_d;
  logic               ovf_q, ovf_d;
  logic               sel_q, sel_d;
  logic               fd_q, fd_d;
  logic               push_w, pop_w;
  logic               full_w, empty_w;
  logic               beat_w;
  logic               sof_w, eol_w, eof_w;
  logic [23:0]        rgb_w;
  pair_t              wr_w, head_w;
  logic [ENTRY_W-1:0] dout_w;

  pix_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (HRESETn),
    .push_i  (push_w),
    .din_i   (wr_w),
    .pop_i   (pop_w),
    .dout_o  (dout_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    geom_d  = geom_q;
    ovf_d   = ovf_q;
    push_w  = 1'b0;
    col_w   = col_q;
    row_w   = row_q;
    act_w   = (state_q == ST_ACTIVE);
    // VSYNC takes effect before a same-cycle pair
    if (bus.VSYNC) begin
      if (act_w)
        geom_d = 1'b1;
      state_d = ST_ACTIVE;
      col_w   = '0;
      row_w   = '0;
      col_d   = '0;
      row_d   = '0;
      act_w   = 1'b1;
    end
    wr_w.sof = (col_w == '0) && (row_w == '0);
    wr_w.eol = (col_w == COL_LAST);
    wr_w.eof = (col_w == COL_LAST) && (row_w == ROW_LAST);
    wr_w.px1 = {bus.DATA_R1, bus.DATA_G1, bus.DATA_B1};
    wr_w.px0 = {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};
    if (bus.HSYNC) begin
      if (!act_w) begin
        geom_d = 1'b1;
      end else begin
        if (!full_w || pop_w)
          push_w = 1'b1;
        else
          ovf_d = 1'b1;
        // counters advance even on a drop
        if (wr_w.eof) begin
          state_d = ST_DONE;
          col_d   = '0;
          row_d   = '0;
        end else if (wr_w.eol) begin
          col_d = '0;
          row_d = row_w + RW'(1);
        end else begin
          col_d = col_w + CW'(2);
        end
      end
    end
  end

  assign head_w = pair_t'(dout_w);
  assign rgb_w  = sel_q ? head_w.px1 : head_w.px0;
  assign sof_w  = !empty_w && !sel_q && head_w.sof;
  assign eol_w  = !empty_w && sel_q && head_w.eol;
  assign eof_w  = !empty_w && sel_q && head_w.eof;
  assign beat_w = !empty_w && bus.out_ready;
  assign pop_w  = beat_w && sel_q;
  assign sel_d  = beat_w ? !sel_q : sel_q;
  assign fd_d   = beat_w && eof_w;

  assign bus.out_valid = !empty_w;
  assign bus.out_rgb   = empty_w ? '0 : rgb_w;
  assign bus.out_sof   = sof_w;
  assign bus.out_eol   = eol_w;
  assign bus.out_eof   = eof_w;

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      geom_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      geom_q  <= geom_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
    end
  end

  assign frame_done = fd_q;
  assign ovf_err    = ovf_q;
  assign geom_err   = geom_q;

`ifdef PIX_CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_d;

  // sof beat restarts from the CCITT seed
  always_comb begin
    crc_d = crc_q;
    if (beat_w)
      crc_d = crc16_px(sof_w ? 16'hFFFF : crc_q, rgb_w);
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn)
      crc_q <= '0;
    else
      crc_q <= crc_d;
  end

  assign frame_crc = crc_q;
`endif

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Scoreboard bench for pixel_stream_capture (WIDTH=8, HEIGHT=2, FIFO_DEPTH=4).
// Frame CRC is compared when PIX_CAPTURE_CRC_EN is defined.
module tb_pixel_stream_capture;
  import pixel_stream_capture_pkg::*;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int D   = 4;
  localparam int NP  = W * H / 2;
  localparam int PPL = W / 2;

  logic clk = 1'b0;
  logic rst;
  logic frame_done, ovf_err, geom_err;
`ifdef PIX_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  always #5 clk = ~clk;

  pixel_stream_capture_if bus();

  pixel_stream_capture #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (D)
  ) dut (
    .HCLK       (clk),
    .HRESETn    (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .ovf_err    (ovf_err),
    .geom_err   (geom_err)
`ifdef PIX_CAPTURE_CRC_EN
    ,
    .frame_crc  (frame_crc)
`endif
  );

  int checks = 0;
  int errors = 0;

  // expected beat: {rgb, sof, eol, eof}
  logic [26:0] exp_q[$];

  // reference model: occupancy in pairs, frame position as pair index
  int m_occ, m_idx;
  bit m_half, m_act, e_geom, e_ovf;

  bit          in_rst = 1'b1;
  bit          stall_prev, fd_pend;
  logic [26:0] held;
  logic [15:0] crc_m;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_ref(logic [15:0] c, logic [23:0] rgb);
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = rgb[23-8*k -: 8];
      c = c ^ {b, 8'h00};
      for (int j = 0; j < 8; j++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic cycle(bit vs, bit hs, bit rdy,
                       logic [23:0] p0, logic [23:0] p1);
    bit valid, pop, sof, eol, eof;
    bus.VSYNC     = vs;
    bus.HSYNC     = hs;
    bus.DATA_R0   = p0[23:16];
    bus.DATA_G0   = p0[15:8];
    bus.DATA_B0   = p0[7:0];
    bus.DATA_R1   = p1[23:16];
    bus.DATA_G1   = p1[15:8];
    bus.DATA_B1   = p1[7:0];
    bus.out_ready = rdy;
    valid = (m_occ > 0);
    pop   = valid && m_half && rdy;
    if (vs) begin
      if (m_act) e_geom = 1'b1;
      m_act = 1'b1;
      m_idx = 0;
    end
    if (hs) begin
      if (!m_act) begin
        e_geom = 1'b1;
      end else begin
        sof = (m_idx == 0);
        eol = (m_idx % PPL) == PPL - 1;
        eof = (m_idx == NP - 1);
        if (m_occ < D || pop) begin
          exp_q.push_back({p0, sof, 1'b0, 1'b0});
          exp_q.push_back({p1, 1'b0, eol, eof});
          m_occ++;
        end else begin
          e_ovf = 1'b1;
        end
        m_idx++;
        if (eof) begin
          m_act = 1'b0;
          m_idx = 0;
        end
      end
    end
    if (pop) m_occ--;
    if (valid && rdy) m_half = !m_half;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, rdy, '0, '0);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    bus.VSYNC = 1'b0;
    bus.HSYNC = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rgb", 32'(bus.out_rgb), 32'd0);
    chk("rst_flags", 32'({frame_done, ovf_err, geom_err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_occ = 0;
    m_idx = 0;
    m_half = 1'b0;
    m_act = 1'b0;
    e_geom = 1'b0;
    e_ovf = 1'b0;
    stall_prev = 1'b0;
    fd_pend = 1'b0;
    in_rst = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      idle(1, 1'b1);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    idle(3, 1'b1);
    chk({tag, "_geom"}, 32'(geom_err), 32'(e_geom));
    chk({tag, "_ovf"}, 32'(ovf_err), 32'(e_ovf));
  endtask

  // mode 0: ready high, 1: random, 2: alternating
  function automatic bit rdyf(int mode, int t);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(1, 0));
    return 1'(t % 2);
  endfunction

  task automatic frame(int mode, int max_gap, bit zero);
    int t;
    logic [23:0] a, b;
    t = 0;
    cycle(1'b1, 1'b0, rdyf(mode, t), '0, '0);
    for (int p = 0; p < NP; p++) begin
      t++;
      a = zero ? 24'h0 : 24'($urandom);
      b = zero ? 24'h0 : 24'($urandom);
      cycle(1'b0, 1'b1, rdyf(mode, t), a, b);
      for (int g = $urandom_range(max_gap, 0); g > 0; g--) begin
        t++;
        cycle(1'b0, 1'b0, rdyf(mode, t), '0, '0);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [26:0] got, e;
    if (!in_rst) begin
      got = {bus.out_rgb, bus.out_sof, bus.out_eol, bus.out_eof};
      if (fd_pend) begin
        chk("frame_done", 32'(frame_done), 32'd1);
`ifdef PIX_CAPTURE_CRC_EN
        chk("frame_crc", 32'(frame_crc), 32'(crc_m));
`endif
        fd_pend = 1'b0;
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL spurious_frame_done actual=1 required=0");
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'(got), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'(got), 32'(e));
          if (e[2]) crc_m = 16'hFFFF;
          crc_m = crc_ref(crc_m, e[26:3]);
          if (e[0]) fd_pend = 1'b1;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = got;
    end
  end

  initial begin
    rst = 1'b0;
    bus.VSYNC = 1'b0;
    bus.HSYNC = 1'b0;
    bus.out_ready = 1'b0;
    bus.DATA_R0 = '0;
    bus.DATA_G0 = '0;
    bus.DATA_B0 = '0;
    bus.DATA_R1 = '0;
    bus.DATA_G1 = '0;
    bus.DATA_B1 = '0;
    crc_m = 16'hFFFF;
    @(posedge clk);
    #1;
    do_reset();

    // raster frame, sparse pairs, no backpressure
    cycle(1'b1, 1'b0, 1'b1, '0, '0);
    for (int p = 0; p < NP; p++) begin
      cycle(1'b0, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
      if (p == 0)
        chk("latency", 32'(bus.out_valid), 32'd1);
      idle(2, 1'b1);
    end
    drain("t1");

    // stalled sink, back-to-back pairs overflow
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int p = 0; p < NP; p++)
      cycle(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
    idle(11, 1'b0);
    chk("t2_ovf_set", 32'(ovf_err), 32'd1);
    drain("t2");

    // alternating and random backpressure
    do_reset();
    frame(2, 2, 1'b0);
    frame(1, 2, 1'b0);
    frame(1, 0, 1'b0);
    frame(0, 1, 1'b0);
    drain("t3");

    // geometry errors
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 24'h123456, 24'h654321);
    idle(2, 1'b1);
    chk("t4_geom_idle", 32'(geom_err), 32'd1);
    chk("t4_no_out", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, '0, '0);
    for (int p = 0; p < 3; p++)
      cycle(1'b0, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
    cycle(1'b1, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
    for (int p = 1; p < NP; p++) begin
      cycle(1'b0, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
      idle(1, 1'b1);
    end
    drain("t4");

    // reset in the middle of a frame
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int p = 0; p < 5; p++)
      cycle(1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
    do_reset();
    idle(1, 1'b1);
    chk("t5_empty", 32'(bus.out_valid), 32'd0);
    frame(1, 2, 1'b0);
    drain("t5");

`ifdef PIX_CAPTURE_CRC_EN
    // black frame, CRC over zero bytes
    do_reset();
    frame(0, 2, 1'b1);
    drain("t6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
